// File: rtl/simple_uart_rx_if.sv
// Receiver-side signal bundle: serial pin in, byte plus status strobes out.
// The slave modport belongs to the receiver; the master modport belongs to the line driver/consumer.
interface simple_uart_rx_if;
    logic       rx_bit;
    logic [7:0] rx_value;
    logic       rx_value_ready;
    logic       rx_frame_error;
    logic       rx_busy;

    modport slave (
        input  rx_bit,
        output rx_value,
        output rx_value_ready,
        output rx_frame_error,
        output rx_busy
    );

    modport master (
        output rx_bit,
        input  rx_value,
        input  rx_value_ready,
        input  rx_frame_error,
        input  rx_busy
    );
endinterface

// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled with a prescaled tick.
// Emits a one-cycle ready strobe per good frame, or a one-cycle frame-error strobe.
module simple_uart_rx #(
    parameter int SYSTEM_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic             clock,
    input  logic             srst,
    simple_uart_rx_if.slave  bus
);
    localparam int TICK_DIV = SYSTEM_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW       = $clog2(OVERSAMPLE);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TCNT_MAX  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TCNT_MID  = TW'(OVERSAMPLE / 2 - 1);

    generate
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("simple_uart_rx: SYSTEM_FREQ too low for BAUD_RATE*OVERSAMPLE");
        end
        if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
            $error("simple_uart_rx: OVERSAMPLE must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rxs_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      value_q, value_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            tick;

    // Two-flop synchroniser; resets to the idle line level so reset never fakes a start edge.
    always_ff @(posedge clock) begin
        if (srst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= bus.rx_bit;
            rxs_q   <= sync1_q;
        end
    end

    assign tick = (presc_q == PRESC_MAX);

    always_ff @(posedge clock) begin
        if (srst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            value_q  <= '0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            value_q  <= value_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        value_d  = value_q;
        ready_d  = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Restart the prescaler so every later sample is phase-locked to this edge.
                if (!rxs_q) begin
                    state_d = S_START;
                    presc_d = '0;
                    tcnt_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tcnt_q == TCNT_MID) begin
                        if (!rxs_q) begin
                            state_d  = S_DATA;
                            tcnt_d   = '0;
                            bitcnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tcnt_q == TCNT_MAX) begin
                        tcnt_d   = '0;
                        shift_d  = {rxs_q, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a start edge right after the stop bit is not missed.
                if (tick) begin
                    if (tcnt_q == TCNT_MAX) begin
                        tcnt_d = '0;
                        if (rxs_q) begin
                            value_d = shift_q;
                            ready_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rx_value       = value_q;
    assign bus.rx_value_ready = ready_q;
    assign bus.rx_frame_error = ferr_q;
    assign bus.rx_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_simple_uart_rx.sv
// Scoreboard bench for simple_uart_rx at 160 clocks per bit (TICK_DIV=10, OVERSAMPLE=16).
// Expected bytes are queued as frames are sent and popped by a monitor on each ready strobe.
module tb_simple_uart_rx;
    logic clock = 1'b0;
    logic srst  = 1'b1;

    simple_uart_rx_if bus ();

    simple_uart_rx #(
        .SYSTEM_FREQ(1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clock(clock),
        .srst (srst),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rdy_cnt = 0;
    int         ferr_cnt = 0;
    int         fall_cyc = 0;
    int         rdy_cyc[$];
    logic [7:0] exp_q[$];

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: pops the scoreboard on every ready strobe, checks strobe width and exclusivity.
    initial begin
        logic       prev_rdy;
        logic       prev_ferr;
        logic [7:0] exp_b;
        prev_rdy  = 1'b0;
        prev_ferr = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.rx_value_ready === 1'b1) begin
                rdy_cnt++;
                rdy_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe value=%h expected none", bus.rx_value);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.rx_value !== exp_b) begin
                        errors++;
                        $display("FAIL rx_value got %h expected %h", bus.rx_value, exp_b);
                    end
                end
                checks++;
                if (prev_rdy === 1'b1) begin
                    errors++;
                    $display("FAIL ready_width got 2+ cycles expected 1");
                end
            end
            if (bus.rx_frame_error === 1'b1) begin
                ferr_cnt++;
                checks++;
                if (bus.rx_value_ready !== 1'b0 || prev_ferr === 1'b1) begin
                    errors++;
                    $display("FAIL ferr_strobe ready=%b prev_ferr=%b expected 0/0",
                             bus.rx_value_ready, prev_ferr);
                end
            end
            prev_rdy  = bus.rx_value_ready;
            prev_ferr = bus.rx_frame_error;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int clks, input logic stop_val);
        fall_cyc   = cyc;
        bus.rx_bit = 1'b0;
        hold(clks);
        for (int i = 0; i < 8; i++) begin
            bus.rx_bit = b[i];
            hold(clks);
        end
        bus.rx_bit = stop_val;
        hold(clks);
    endtask

    task automatic wait_rdy(input int target);
        for (int i = 0; i < 4000 && rdy_cnt < target; i++) hold(1);
        checks++;
        if (rdy_cnt != target) begin
            errors++;
            $display("FAIL strobe_count got %0d expected %0d", rdy_cnt, target);
        end
    endtask

    task automatic test_reset();
        srst       = 1'b1;
        bus.rx_bit = 1'b1;
        hold(3);
        srst = 1'b0;
        checks++;
        if (bus.rx_value !== 8'h00 || bus.rx_value_ready !== 1'b0 ||
            bus.rx_frame_error !== 1'b0 || bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got val=%h rdy=%b ferr=%b busy=%b expected 00/0/0/0",
                     bus.rx_value, bus.rx_value_ready, bus.rx_frame_error, bus.rx_busy);
        end
        hold(20);
    endtask

    task automatic test_single();
        int base;
        int lat;
        base = rdy_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 160, 1'b1);
        wait_rdy(base + 1);
        lat = (rdy_cyc.size() > 0) ? rdy_cyc[rdy_cyc.size()-1] - fall_cyc : -1;
        checks++;
        if (lat < 1522 || lat > 1524) begin
            errors++;
            $display("FAIL single_latency got %0d expected 1523+-1", lat);
        end
        checks++;
        if (bus.rx_value !== 8'hA5 || bus.rx_busy !== 1'b0 || ferr_cnt != 0) begin
            errors++;
            $display("FAIL single_after got val=%h busy=%b ferr=%0d expected a5/0/0",
                     bus.rx_value, bus.rx_busy, ferr_cnt);
        end
        hold(50);
    endtask

    task automatic test_back_to_back();
        int base;
        int n;
        base = rdy_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 160, 1'b1);
        send_frame(8'hFF, 160, 1'b1);
        send_frame(8'h55, 160, 1'b1);
        wait_rdy(base + 3);
        n = rdy_cyc.size();
        checks++;
        if (n < 3 || rdy_cyc[n-2] - rdy_cyc[n-3] != 1600 || rdy_cyc[n-1] - rdy_cyc[n-2] != 1600) begin
            errors++;
            $display("FAIL b2b_spacing got %0d/%0d expected 1600/1600",
                     (n >= 3) ? rdy_cyc[n-2] - rdy_cyc[n-3] : -1,
                     (n >= 3) ? rdy_cyc[n-1] - rdy_cyc[n-2] : -1);
        end
        hold(50);
    endtask

    task automatic test_glitch();
        int base;
        int t0;
        int lat;
        base       = rdy_cnt;
        t0         = cyc;
        bus.rx_bit = 1'b0;
        hold(40);
        bus.rx_bit = 1'b1;
        checks++;
        if (bus.rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy got %b expected 1", bus.rx_busy);
        end
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.rx_busy === 1'b0) begin
                lat = cyc - t0;
                break;
            end
            hold(1);
        end
        checks++;
        if (lat < 82 || lat > 84) begin
            errors++;
            $display("FAIL glitch_busy_drop got %0d expected 83+-1", lat);
        end
        hold(100);
        checks++;
        if (rdy_cnt != base || ferr_cnt != 0) begin
            errors++;
            $display("FAIL glitch_strobe got rdy=%0d ferr=%0d expected %0d/0", rdy_cnt, ferr_cnt, base);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 160, 1'b1);
        wait_rdy(base + 1);
        hold(50);
    endtask

    task automatic test_break();
        int base_r;
        int base_f;
        base_r = rdy_cnt;
        base_f = ferr_cnt;
        send_frame(8'h12, 160, 1'b0);
        bus.rx_bit = 1'b0;
        hold(3000);
        checks++;
        if (ferr_cnt != base_f + 1 || rdy_cnt != base_r || bus.rx_value !== 8'h3C) begin
            errors++;
            $display("FAIL break_hold got ferr=%0d rdy=%0d val=%h expected %0d/%0d/3c",
                     ferr_cnt, rdy_cnt, bus.rx_value, base_f + 1, base_r);
        end
        bus.rx_bit = 1'b1;
        hold(20);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 160, 1'b1);
        wait_rdy(base_r + 1);
        checks++;
        if (ferr_cnt != base_f + 1 || bus.rx_value !== 8'h3C) begin
            errors++;
            $display("FAIL break_recover got ferr=%0d val=%h expected %0d/3c",
                     ferr_cnt, bus.rx_value, base_f + 1);
        end
        hold(50);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int base_r;
        int base_f;
        b      = 8'h5A;
        base_r = rdy_cnt;
        base_f = ferr_cnt;
        bus.rx_bit = 1'b0;
        hold(160);
        for (int i = 0; i < 4; i++) begin
            bus.rx_bit = b[i];
            hold(160);
        end
        bus.rx_bit = b[4];
        hold(80);
        srst = 1'b1;
        hold(1);
        srst = 1'b0;
        bus.rx_bit = 1'b1;
        checks++;
        if (bus.rx_value !== 8'h00 || bus.rx_value_ready !== 1'b0 ||
            bus.rx_frame_error !== 1'b0 || bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got val=%h rdy=%b ferr=%b busy=%b expected 00/0/0/0",
                     bus.rx_value, bus.rx_value_ready, bus.rx_frame_error, bus.rx_busy);
        end
        hold(160);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 160, 1'b1);
        wait_rdy(base_r + 1);
        checks++;
        if (bus.rx_value !== 8'h81 || ferr_cnt != base_f) begin
            errors++;
            $display("FAIL midreset_recover got val=%h ferr=%0d expected 81/%0d",
                     bus.rx_value, ferr_cnt, base_f);
        end
        hold(50);
    endtask

    task automatic test_baud_tol();
        int base_r;
        int base_f;
        int rates[2];
        rates[0] = 157;
        rates[1] = 163;
        for (int k = 0; k < 2; k++) begin
            base_r = rdy_cnt;
            base_f = ferr_cnt;
            exp_q.push_back(8'hC3);
            send_frame(8'hC3, rates[k], 1'b1);
            hold(200);
            wait_rdy(base_r + 1);
            checks++;
            if (bus.rx_value !== 8'hC3 || ferr_cnt != base_f) begin
                errors++;
                $display("FAIL baud_%0d got val=%h ferr=%0d expected c3/%0d",
                         rates[k], bus.rx_value, ferr_cnt, base_f);
            end
        end
    endtask

    initial begin
        bus.rx_bit = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_baud_tol();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_uart_rx.md
Name: simple_uart_rx

Overview:
- Standalone UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Counterpart of the UART transmit path.
- Deserialises an asynchronous rx_bit into bytes, with a one-cycle ready strobe per valid frame.
- Sits between a board pin and a byte-oriented consumer (command parser, FIFO).

Parameters:
SYSTEM_FREQ, 50_000_000, clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
OVERSAMPLE, 16, ticks per bit period; even, >= 4
(derived) TICK_DIV = SYSTEM_FREQ / (BAUD_RATE * OVERSAMPLE), integer truncation; must be >= 1 (elaboration check)

Ports:
clock  input  1  system clock; all logic on posedge
srst  input  1  synchronous reset, active-high
rx_bit  input  1  asynchronous serial input, idle 1
rx_value  output  8  last correctly received byte
rx_value_ready  output  1  one-cycle strobe: rx_value updated this cycle
rx_frame_error  output  1  one-cycle strobe: stop bit sampled 0
rx_busy  output  1  1 while a frame is being received (any state except IDLE)

Behaviour:
- Reset:
  - One clock, synchronous, active-high (srst).
  - On srst: rx_value=0x00, rx_value_ready=0, rx_frame_error=0, rx_busy=0, state=IDLE.
  - Synchroniser flops reset to 1; prescaler and bit counters reset to 0.
  - srst mid-frame aborts the frame silently; no strobe is generated.
- Input synchroniser:
  - Two flops on rx_bit. All logic uses the second-stage value rxs.
  - Fixed 2-cycle input latency.
- Prescaler:
  - Counter 0..TICK_DIV-1; tick=1 for one cycle when counter==TICK_DIV-1, then wraps to 0.
  - Forced to 0 on the IDLE->START transition so that sampling aligns to the detected edge.
- Tick counter:
  - Counts ticks within a bit, 0..OVERSAMPLE-1.
  - Bit counter 0..7.
- FSM:
  - IDLE: rxs==0 -> START; clear tick counter.
  - START: at the tick where tick counter reaches OVERSAMPLE/2-1 (mid start bit), sample rxs:
    - rxs==0 -> DATA; clear tick counter and bit counter.
    - rxs==1 -> IDLE (glitch rejected, no strobe).
  - DATA: every OVERSAMPLE ticks (tick counter == OVERSAMPLE-1), sample rxs into shift[7] and shift right.
    - After the 8th sample -> STOP. Bit 0 is received first.
  - STOP: after OVERSAMPLE ticks, sample rxs:
    - rxs==1: rx_value<=shift and rx_value_ready=1 on the next cycle; -> IDLE.
    - rxs==0: rx_frame_error=1 on the next cycle, rx_value unchanged; -> BREAK.
  - BREAK: wait until rxs==1, then -> IDLE. A held-low line yields exactly one frame_error.
- Strobes:
  - rx_value_ready and rx_frame_error are never high in the same cycle.
  - Each is high exactly one cycle per frame.
  - No backpressure: the consumer must take the byte in the strobe cycle.
  - rx_value holds until the next valid frame.
- Back-to-back frames:
  - Return to IDLE at mid-stop bit, so a start edge arriving right after a full stop bit is detected.
  - A sender-clock mismatch of ±2% is tolerated.
- Timing (TICK_DIV=10, OVERSAMPLE=16):
  - Mid-start sample is 80 clocks after edge detection.
  - Stop sample is 80+9*160=1520 clocks after detection.
  - Strobe is at detection+1521; detection is at pin falling edge +2.

Test Plan:
(Bench for all scenarios: SYSTEM_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 -> TICK_DIV=10, 160 clocks/bit.)
- Single frame: send 0xA5 -> rx_value=0xA5, rx_value_ready high exactly 1 cycle, 1523±1 clocks after pin falling edge; rx_busy low afterwards; rx_frame_error stays 0.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap -> three ready strobes, values 0x00, 0xFF, 0x55 in order, 1600 clocks apart.
- Glitch: pulse rx_bit low for 40 clocks -> no strobe; rx_busy returns to 0 ~80 clocks after detection; a subsequent 0x3C is received correctly.
- Framing/break: send 0x12 with stop bit 0, then hold the line low for 3000 clocks, release, send 0x3C -> exactly one rx_frame_error pulse; rx_value stays at its previous value until the 0x3C strobe gives rx_value=0x3C.
- Reset mid-frame: assert srst for 1 cycle during bit 4 of 0x5A -> all outputs 0 the next cycle and no strobe for 0x5A; after the line idles high for 160 clocks, send 0x81 -> rx_value=0x81 with a single strobe.
- Baud tolerance: transmit 0xC3 at 160±3 clocks/bit (±2%) -> rx_value=0xC3 with no frame error in both cases.
